execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 186 ++++++++++++++++++
 tb/tb_execute_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage of the pipeline. Consumes the ID/EX register contents,
//   applies operand forwarding, runs the ALU and resolves branches and jumps.
//   The resolved outcome is compared with the fetch-time prediction, and on a
//   mismatch fetch is told, in the same cycle, where to restart. Results are
//   captured into the EX/MEM pipeline register. Two saturating counters track
//   resolved control transfers and mispredictions.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   RD1E, RD2E               register operands from ID/EX
//   PCE, PCPlus4E, ImmExtE   PC, PC+4, extended immediate
//   Rs1E, Rs2E, RdE          register indices
//   RegWriteE .. ALUSrcE     control bits; ResultSrcE, ALUControlE selects
//   TakingBranchE            fetch predicted taken (already went to PCE+ImmExtE)
//   ByteAddressE, ReadEnableE memory access qualifiers
//   ForwardAE, ForwardBE     00/11 register file, 01 ResultW, 10 ALUResultM
//   ResultW                  writeback value for forwarding
//   StallM, FlushM           EX/MEM hold / clear (flush wins)
//   RedirectE, RedirectPCE   misprediction and corrected fetch address
//   *M outputs               EX/MEM pipeline register
//   Rs1EH, Rs2EH, RdEH, ResultSrcE0H  copies for the hazard unit
//   BranchCount, MispredictCount     saturating performance counters
//
// Handshake: there is no valid/ready pair here. The stage advances on every
// rising clk edge where StallM=0 and FlushM=0; StallM=1 holds EX/MEM, and
// FlushM=1 inserts an all-zero bubble regardless of StallM.
module execute_stage #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] RD1E,
  input  logic [WORD_SIZE-1:0] RD2E,
  input  logic [WORD_SIZE-1:0] PCE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  input  logic [WORD_SIZE-1:0] ImmExtE,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic                 ALUSrcE,
  input  logic [1:0]           ResultSrcE,
  input  logic [2:0]           ALUControlE,
  input  logic                 TakingBranchE,
  input  logic                 ByteAddressE,
  input  logic                 ReadEnableE,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  input  logic [WORD_SIZE-1:0] ResultW,
  input  logic                 StallM,
  input  logic                 FlushM,
  output logic                 RedirectE,
  output logic [WORD_SIZE-1:0] RedirectPCE,
  output logic [WORD_SIZE-1:0] ALUResultM,
  output logic [WORD_SIZE-1:0] WriteDataM,
  output logic [WORD_SIZE-1:0] PCPlus4M,
  output logic [4:0]           RdM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 ByteAddressM,
  output logic                 ReadEnableM,
  output logic [1:0]           ResultSrcM,
  output logic [4:0]           Rs1EH,
  output logic [4:0]           Rs2EH,
  output logic [4:0]           RdEH,
  output logic                 ResultSrcE0H,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  logic [WORD_SIZE-1:0] srcA;
  logic [WORD_SIZE-1:0] srcB;
  logic [WORD_SIZE-1:0] writeData;
  logic [WORD_SIZE-1:0] aluResult;
  logic [WORD_SIZE-1:0] target;
  logic                 zero;
  logic                 actualTaken;
  logic                 advance;

  // Operand forwarding; the unused code 11 falls back to the register file.
  always_comb begin
    srcA = RD1E;
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUResultM;
      default: srcA = RD1E;
    endcase
  end

  always_comb begin
    writeData = RD2E;
    case (ForwardBE)
      2'b01:   writeData = ResultW;
      2'b10:   writeData = ALUResultM;
      default: writeData = RD2E;
    endcase
  end

  assign srcB = ALUSrcE ? ImmExtE : writeData;

  always_comb begin
    aluResult = '0;
    case (ALUControlE)
      3'b000: aluResult = srcA + srcB;
      3'b001: aluResult = srcA - srcB;
      3'b010: aluResult = srcA & srcB;
      3'b011: aluResult = srcA | srcB;
      3'b100: aluResult = srcA ^ srcB;
      3'b101: aluResult = {{(WORD_SIZE-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      3'b110: aluResult = srcA << srcB[4:0];
      3'b111: aluResult = srcA >> srcB[4:0];
      default: aluResult = '0;
    endcase
  end

  assign zero        = (aluResult == '0);
  assign actualTaken = JumpE | (BranchE & zero);
  assign target      = PCE + ImmExtE;

  // A predicted-taken branch already went to the target, so only the
  // taken-but-not-predicted case needs the target; every other redirect
  // (and the idle value) is the fall-through address.
  assign RedirectE   = actualTaken ^ TakingBranchE;
  assign RedirectPCE = (actualTaken & ~TakingBranchE) ? target : PCPlus4E;

  assign Rs1EH        = Rs1E;
  assign Rs2EH        = Rs2E;
  assign RdEH         = RdE;
  assign ResultSrcE0H = ResultSrcE[0];

  assign advance = ~StallM & ~FlushM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUResultM   <= '0;
      WriteDataM   <= '0;
      PCPlus4M     <= '0;
      RdM          <= '0;
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      ByteAddressM <= 1'b0;
      ReadEnableM  <= 1'b0;
      ResultSrcM   <= '0;
    end else if (FlushM) begin
      ALUResultM   <= '0;
      WriteDataM   <= '0;
      PCPlus4M     <= '0;
      RdM          <= '0;
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      ByteAddressM <= 1'b0;
      ReadEnableM  <= 1'b0;
      ResultSrcM   <= '0;
    end else if (!StallM) begin
      ALUResultM   <= aluResult;
      WriteDataM   <= writeData;
      PCPlus4M     <= PCPlus4E;
      RdM          <= RdE;
      RegWriteM    <= RegWriteE;
      MemWriteM    <= MemWriteE;
      ByteAddressM <= ByteAddressE;
      ReadEnableM  <= ReadEnableE;
      ResultSrcM   <= ResultSrcE;
    end
  end

  // Counters step only when the instruction leaves the stage, so a stalled
  // branch is counted once; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (advance) begin
      if ((BranchE | JumpE) && (BranchCount != {CNT_WIDTH{1'b1}}))
        BranchCount <= BranchCount + 1'b1;
      if (RedirectE && (MispredictCount != {CNT_WIDTH{1'b1}}))
        MispredictCount <= MispredictCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  localparam int W  = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic TakingBranchE, ByteAddressE, ReadEnableE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallM, FlushM;
  logic RedirectE;
  logic [W-1:0] RedirectPCE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0] RdM;
  logic RegWriteM, MemWriteM, ByteAddressM, ReadEnableM;
  logic [1:0] ResultSrcM;
  logic [4:0] Rs1EH, Rs2EH, RdEH;
  logic ResultSrcE0H;
  logic [CW-1:0] BranchCount, MispredictCount;

  execute_stage #(.WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .TakingBranchE(TakingBranchE), .ByteAddressE(ByteAddressE), .ReadEnableE(ReadEnableE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallM(StallM), .FlushM(FlushM),
    .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ByteAddressM(ByteAddressM), .ReadEnableM(ReadEnableM), .ResultSrcM(ResultSrcM),
    .Rs1EH(Rs1EH), .Rs2EH(Rs2EH), .RdEH(RdEH), .ResultSrcE0H(ResultSrcE0H),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ctl bits: [7]RegWrite [6]MemWrite [5]Jump [4]Branch [3]ALUSrc
  //           [2]TakingBranch [1]ByteAddress [0]ReadEnable
  typedef struct {
    logic [W-1:0] rd1, rd2, pc, imm, resW;
    logic [4:0]   rs1, rs2, rd;
    logic [1:0]   fwdA, fwdB, resSrc;
    logic [2:0]   alu;
    logic [7:0]   ctl;
    logic         expRedir;
    logic [W-1:0] expRpc, expAlu, expWd;
    logic [CW-1:0] expBc, expMc;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic driveVec(input vec_t v);
    RD1E = v.rd1; RD2E = v.rd2; PCE = v.pc; PCPlus4E = v.pc + 32'd4;
    ImmExtE = v.imm; ResultW = v.resW;
    Rs1E = v.rs1; Rs2E = v.rs2; RdE = v.rd;
    ForwardAE = v.fwdA; ForwardBE = v.fwdB; ResultSrcE = v.resSrc;
    ALUControlE = v.alu;
    {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, TakingBranchE,
     ByteAddressE, ReadEnableE} = v.ctl;
  endtask

  function automatic logic [5:0] ctlOut(input vec_t v);
    return {v.ctl[7], v.ctl[6], v.resSrc, v.ctl[1], v.ctl[0]};
  endfunction

  task automatic checkM(input string tag, input vec_t v, input logic [W-1:0] expAlu);
    chk({tag, " ALUResultM"}, ALUResultM, expAlu);
    chk({tag, " WriteDataM"}, WriteDataM, v.expWd);
    chk({tag, " PCPlus4M"}, PCPlus4M, v.pc + 32'd4);
    chk({tag, " RdM"}, {27'd0, RdM}, {27'd0, v.rd});
    chk({tag, " ctlM"}, {26'd0, RegWriteM, MemWriteM, ResultSrcM, ByteAddressM, ReadEnableM},
        {26'd0, ctlOut(v)});
    chk({tag, " BranchCount"}, {28'd0, BranchCount}, {28'd0, v.expBc});
    chk({tag, " MispredictCount"}, {28'd0, MispredictCount}, {28'd0, v.expMc});
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " ALUResultM"}, ALUResultM, '0);
    chk({tag, " WriteDataM"}, WriteDataM, '0);
    chk({tag, " PCPlus4M"}, PCPlus4M, '0);
    chk({tag, " ctlM"}, {21'd0, RdM, RegWriteM, MemWriteM, ResultSrcM, ByteAddressM, ReadEnableM}, '0);
  endtask

  // One advancing cycle: drive after negedge, check redirect before the
  // edge, check EX/MEM after it.
  task automatic runVec(input string tag, input vec_t v);
    logic [W-1:0] e;
    @(negedge clk);
    driveVec(v);
    StallM = 1'b0; FlushM = 1'b0;
    #1;
    chk({tag, " RedirectE"}, {31'd0, RedirectE}, {31'd0, v.expRedir});
    chk({tag, " RedirectPCE"}, RedirectPCE, v.expRpc);
    chk({tag, " hazCopies"}, {16'd0, Rs1EH, Rs2EH, RdEH, ResultSrcE0H},
        {16'd0, v.rs1, v.rs2, v.rd, v.resSrc[0]});
    exp_q.push_back(v.expAlu);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkM(tag, v, e);
  endtask

  // ---------------- test ----------------
  vec_t s;

  initial begin
    //               rd1          rd2          pc      imm          resW     rs1 rs2 rd fwdA   fwdB   rSrc   alu     ctl           rdr rpc     alu          wd       bc mc
    vecs.push_back('{32'd5,       32'd7,       32'h200, 32'd0,      32'd0,     1, 2, 3, 2'b00, 2'b00, 2'b00, 3'b000, 8'b1000_0000, 0, 32'h204, 32'd12,      32'd7,      0, 0});
    vecs.push_back('{32'd100,     32'd0,       32'h200, 32'd0,      32'd0,     1, 0, 4, 2'b00, 2'b00, 2'b00, 3'b000, 8'b1000_1000, 0, 32'h204, 32'd100,     32'd0,      0, 0});
    vecs.push_back('{32'd5,       32'd0,       32'h200, 32'd1,      32'd0,     4, 0, 5, 2'b10, 2'b00, 2'b00, 3'b000, 8'b1000_1000, 0, 32'h204, 32'd101,     32'd0,      0, 0});
    vecs.push_back('{32'h1000,    32'h11,      32'h200, 32'd8,      32'hAB,    5, 6, 0, 2'b00, 2'b01, 2'b00, 3'b000, 8'b0100_1010, 0, 32'h204, 32'h1008,    32'hAB,     0, 0});
    vecs.push_back('{32'h999,     32'h22,      32'h200, 32'd4,      32'h300,   2, 3, 7, 2'b01, 2'b00, 2'b01, 3'b000, 8'b1000_1001, 0, 32'h204, 32'h304,     32'h22,     0, 0});
    vecs.push_back('{32'd3,       32'd5,       32'h200, 32'd0,      32'd0,     1, 2, 8, 2'b00, 2'b00, 2'b00, 3'b001, 8'b1000_0000, 0, 32'h204, 32'hFFFFFFFE, 32'd5,     0, 0});
    vecs.push_back('{32'hF0F0,    32'hFF00,    32'h200, 32'd0,      32'd0,     1, 2, 9, 2'b00, 2'b00, 2'b00, 3'b010, 8'b1000_0000, 0, 32'h204, 32'hF000,    32'hFF00,   0, 0});
    vecs.push_back('{32'hF0F0,    32'hFF00,    32'h200, 32'd0,      32'd0,     1, 2, 9, 2'b00, 2'b00, 2'b00, 3'b011, 8'b1000_0000, 0, 32'h204, 32'hFFF0,    32'hFF00,   0, 0});
    vecs.push_back('{32'hF0F0,    32'hFF00,    32'h200, 32'd0,      32'd0,     1, 2, 9, 2'b00, 2'b00, 2'b00, 3'b100, 8'b1000_0000, 0, 32'h204, 32'h0FF0,    32'hFF00,   0, 0});
    vecs.push_back('{32'hFFFFFFFF, 32'd1,      32'h200, 32'd0,      32'd0,     1, 2, 10, 2'b00, 2'b00, 2'b00, 3'b101, 8'b1000_0000, 0, 32'h204, 32'd1,      32'd1,      0, 0});
    vecs.push_back('{32'd1,       32'hFFFFFFFF, 32'h200, 32'd0,     32'd0,     1, 2, 10, 2'b00, 2'b00, 2'b00, 3'b101, 8'b1000_0000, 0, 32'h204, 32'd0,      32'hFFFFFFFF, 0, 0});
    vecs.push_back('{32'd1,       32'h24,      32'h200, 32'd0,      32'd0,     1, 2, 11, 2'b00, 2'b00, 2'b00, 3'b110, 8'b1000_0000, 0, 32'h204, 32'h10,     32'h24,     0, 0});
    vecs.push_back('{32'h80000000, 32'd31,     32'h200, 32'd0,      32'd0,     1, 2, 12, 2'b00, 2'b00, 2'b00, 3'b111, 8'b1000_0000, 0, 32'h204, 32'd1,      32'd31,     0, 0});
    vecs.push_back('{32'd7,       32'd2,       32'h200, 32'd0,      32'd99,    1, 2, 13, 2'b11, 2'b11, 2'b00, 3'b000, 8'b1000_0000, 0, 32'h204, 32'd9,      32'd2,      0, 0});
    vecs.push_back('{32'd9,       32'd9,       32'h40,  32'h10,     32'd0,     1, 2, 0, 2'b00, 2'b00, 2'b00, 3'b001, 8'b0001_0000, 1, 32'h50,  32'd0,       32'd9,      1, 1});
    vecs.push_back('{32'd9,       32'd8,       32'h40,  32'h10,     32'd0,     1, 2, 0, 2'b00, 2'b00, 2'b00, 3'b001, 8'b0001_0100, 1, 32'h44,  32'd1,       32'd8,      2, 2});
    vecs.push_back('{32'd0,       32'd0,       32'h100, 32'h20,     32'd0,     0, 0, 1, 2'b00, 2'b00, 2'b10, 3'b000, 8'b1010_0100, 0, 32'h104, 32'd0,       32'd0,      3, 2});
    vecs.push_back('{32'd1,       32'd2,       32'h60,  32'h8,      32'd0,     1, 2, 0, 2'b00, 2'b00, 2'b00, 3'b001, 8'b0001_0000, 0, 32'h64,  32'hFFFFFFFF, 32'd2,     4, 2});
    vecs.push_back('{32'd0,       32'd0,       32'h80,  32'hFFFFFFF0, 32'd0,   0, 0, 1, 2'b00, 2'b00, 2'b10, 3'b000, 8'b1010_0000, 1, 32'h70,  32'd0,       32'd0,      5, 3});

    // reset block
    StallM = 1'b0; FlushM = 1'b0;
    driveVec(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    chk("reset counters", {24'd0, BranchCount, MispredictCount}, '0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i]);

    // Mispredicted branch held three cycles, then released.
    s = '{32'd4, 32'd4, 32'h40, 32'h10, 32'd0, 1, 2, 0, 2'b00, 2'b00, 2'b00, 3'b001,
          8'b0001_0000, 1, 32'h50, 32'd0, 32'd4, 6, 4};
    @(negedge clk);
    driveVec(s);
    StallM = 1'b1;
    #1;
    chk("stall RedirectE", {31'd0, RedirectE}, 32'd1);
    chk("stall RedirectPCE", RedirectPCE, 32'h50);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall WriteDataM", WriteDataM, 32'd0);
      chk("stall PCPlus4M", PCPlus4M, 32'h84);
      chk("stall RdM", {27'd0, RdM}, 32'd1);
      chk("stall counters", {24'd0, BranchCount, MispredictCount}, {24'd0, 4'd5, 4'd3});
    end
    @(negedge clk);
    StallM = 1'b0;
    @(posedge clk);
    #1;
    checkM("release", s, 32'd0);

    // Flush wins over stall.
    @(negedge clk);
    s.rd = 5'd9;
    s.ctl = 8'b1001_0000;
    driveVec(s);
    StallM = 1'b1; FlushM = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("flush+stall");
    chk("flush counters", {24'd0, BranchCount, MispredictCount}, {24'd0, 4'd6, 4'd4});

    // Saturation: 12 more mispredicted branches, then one more.
    @(negedge clk);
    StallM = 1'b0; FlushM = 1'b0;
    s.ctl = 8'b0001_0000;
    driveVec(s);
    repeat (12) @(posedge clk);
    #1;
    chk("sat BranchCount", {28'd0, BranchCount}, 32'd15);
    chk("sat MispredictCount", {28'd0, MispredictCount}, 32'd15);
    @(posedge clk);
    #1;
    chk("sat+1 BranchCount", {28'd0, BranchCount}, 32'd15);
    chk("sat+1 MispredictCount", {28'd0, MispredictCount}, 32'd15);

    // Asynchronous reset mid-stall, between edges.
    @(negedge clk);
    driveVec(vecs[3]);
    StallM = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("async reset");
    chk("async reset counters", {24'd0, BranchCount, MispredictCount}, '0);
    @(negedge clk);
    rst = 1'b1;
    runVec("post-reset", vecs[0]);

    chk("exp_q drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
